// File: rtl/mult_stream_pkg.sv
// Shared definitions for the multiplier product stream: default widths,
// the accumulator FSM state type and a constant clog2 helper.
package mult_stream_pkg;

    localparam int PROD_W_DEF  = 32;
    localparam int ACC_W_DEF   = 48;
    localparam int MAX_LEN_DEF = 1024;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    // Smallest r with 2**r >= v; used as clog2(MAX_LEN+1) for the beat counter.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums a stream of unsigned products into a wide accumulator and presents
// one dot-product result per vector (closed by in_last or MAX_LEN beats).
module product_accumulator
    import mult_stream_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    localparam int CNT_W  = clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow,
    output logic              out_forced
);

    // Handshake: a beat transfers on a rising edge where in_valid & in_ready;
    // a result transfers where out_valid & out_ready. A held result stays
    // stable until it transfers, and in_ready looks through to out_ready so
    // a retiring result and a new beat can share one cycle.

    acc_state_t         state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;

    logic               accept;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   sum_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt_next;
    logic               closing;

    assign in_ready = (state == ACCUM) | out_ready;
    assign accept   = in_valid & in_ready;

    // One extra bit captures the wrap out of the accumulator.
    assign sum_wide = {1'b0, acc} + (ACC_W + 1)'(in_product);
    assign sum_next = sum_wide[ACC_W-1:0];
    assign carry    = sum_wide[ACC_W];
    assign cnt_next = cnt + 1'b1;
    assign closing  = in_last | (cnt_next == CNT_W'(MAX_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_forced   <= 1'b0;
        end else begin
            if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
                state     <= ACCUM;
            end
            // A closing beat overrides the retire above, giving back-to-back results.
            if (accept) begin
                if (closing) begin
                    out_sum      <= sum_next;
                    out_count    <= cnt_next;
                    out_overflow <= ovf | carry;
                    out_forced   <= ~in_last;
                    out_valid    <= 1'b1;
                    state        <= DONE;
                    acc          <= '0;
                    cnt          <= '0;
                    ovf          <= 1'b0;
                end else begin
                    acc <= sum_next;
                    cnt <= cnt_next;
                    ovf <= ovf | carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default build and an
// ACC_W=32 / MAX_LEN=4 build, checked against a transaction-level model.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv[2];
    logic        il[2];
    logic        ordy[2];
    logic [31:0] ip[2];
    logic        ir[2];
    logic        ov[2];
    logic        oovf[2];
    logic        ofor[2];
    logic [47:0] sum0;
    logic [31:0] sum1;
    logic [10:0] cnt0;
    logic [2:0]  cnt1;

    longint unsigned act_sum[2];
    longint unsigned act_cnt[2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    product_accumulator d0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_product(ip[0]), .in_last(il[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(sum0), .out_count(cnt0),
        .out_overflow(oovf[0]), .out_forced(ofor[0])
    );

    product_accumulator #(.ACC_W(32), .MAX_LEN(4)) d1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_product(ip[1]), .in_last(il[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(sum1), .out_count(cnt1),
        .out_overflow(oovf[1]), .out_forced(ofor[1])
    );

    always_comb begin
        act_sum[0] = 64'(sum0);
        act_sum[1] = 64'(sum1);
        act_cnt[0] = 64'(cnt0);
        act_cnt[1] = 64'(cnt1);
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: exact (unbounded) vector total; the result is that total modulo
    // 2^ACC_W, and it overflowed iff the exact total reached 2^ACC_W.
    typedef struct {
        bit              valid;
        longint unsigned total;
        int              cnt;
        longint unsigned r_sum;
        int              r_cnt;
        bit              r_ovf;
        bit              r_forced;
    } model_t;

    model_t      m[2];
    int unsigned accw[2]   = '{48, 32};
    int          maxlen[2] = '{1024, 4};

    always @(posedge clk or posedge rst) begin
        bit take;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m[i].valid = 0; m[i].total = 0; m[i].cnt = 0;
                m[i].r_sum = 0; m[i].r_cnt = 0; m[i].r_ovf = 0; m[i].r_forced = 0;
            end else begin
                take = iv[i] && (!m[i].valid || ordy[i]);
                if (m[i].valid && ordy[i]) m[i].valid = 0;
                if (take) begin
                    m[i].total += 64'(ip[i]);
                    m[i].cnt++;
                    if (il[i] || m[i].cnt == maxlen[i]) begin
                        m[i].r_sum    = m[i].total & ((64'd1 << accw[i]) - 1);
                        m[i].r_ovf    = (m[i].total >> accw[i]) != 0;
                        m[i].r_cnt    = m[i].cnt;
                        m[i].r_forced = !il[i];
                        m[i].valid    = 1;
                        m[i].total    = 0;
                        m[i].cnt      = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d.in_ready", i), 64'(ir[i]), 64'(!m[i].valid || ordy[i]));
            check($sformatf("d%0d.out_valid", i), 64'(ov[i]), 64'(m[i].valid));
            if (m[i].valid || rst) begin
                check($sformatf("d%0d.out_sum", i), act_sum[i], m[i].r_sum);
                check($sformatf("d%0d.out_count", i), act_cnt[i], 64'(m[i].r_cnt));
                check($sformatf("d%0d.out_overflow", i), 64'(oovf[i]), 64'(m[i].r_ovf));
                check($sformatf("d%0d.out_forced", i), 64'(ofor[i]), 64'(m[i].r_forced));
            end
        end
    end

    // Presents one beat, holds it until accepted (bounded), returns at edge+1.
    task automatic send(input int i, input logic [31:0] p, input logic last);
        int k;
        iv[i] = 1'b1; ip[i] = p; il[i] = last;
        k = 0;
        @(negedge clk);
        while (!ir[i] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout d%0d: in_ready stayed 0 for %0d cycles", i, k);
        end
        @(posedge clk);
        #1;
        iv[i] = 1'b0; il[i] = 1'b0;
    endtask

    task automatic expect_result(input int i, input string tag, input longint unsigned s,
                                 input longint unsigned c, input logic o, input logic f);
        check({tag, ".valid"}, 64'(ov[i]), 64'd1);
        check({tag, ".sum"}, act_sum[i], s);
        check({tag, ".count"}, act_cnt[i], c);
        check({tag, ".overflow"}, 64'(oovf[i]), 64'(o));
        check({tag, ".forced"}, 64'(ofor[i]), 64'(f));
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; il[i] = 1'b0; ip[i] = '0; ordy[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("reset.valid0", 64'(ov[0]), 64'd0);
        check("reset.sum0", act_sum[0], 64'd0);
        check("reset.count1", act_cnt[1], 64'd0);
        check("reset.in_ready0", 64'(ir[0]), 64'd1);

        // 12 + 30 + 56
        send(0, 32'd12, 1'b0);
        send(0, 32'd30, 1'b0);
        check("t1.no_early_valid", 64'(ov[0]), 64'd0);
        send(0, 32'd56, 1'b1);
        expect_result(0, "t1", 64'd98, 64'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t1.retired", 64'(ov[0]), 64'd0);

        // stall: result held, presented beat not consumed
        ordy[0] = 1'b0;
        send(0, 32'd7, 1'b1);
        iv[0] = 1'b1; ip[0] = 32'd100; il[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t2.in_ready_low", 64'(ir[0]), 64'd0);
            check("t2.sum_stable", act_sum[0], 64'd7);
        end
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        send(0, 32'd100, 1'b0);
        send(0, 32'd5, 1'b1);
        expect_result(0, "t2", 64'd105, 64'd2, 1'b0, 1'b0);

        // back-to-back single-beat vectors
        for (int k = 1; k <= 4; k++) begin
            send(0, 32'(k), 1'b1);
            expect_result(0, $sformatf("t3.%0d", k), 64'(k), 64'd1, 1'b0, 1'b0);
            check("t3.in_ready", 64'(ir[0]), 64'd1);
        end
        @(posedge clk); #1;
        check("t3.drained", 64'(ov[0]), 64'd0);

        // reset mid-vector, then while a result is held
        send(0, 32'd9, 1'b0);
        send(0, 32'd9, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t4.rst_sum", act_sum[0], 64'd0);
        check("t4.rst_count", act_cnt[0], 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        send(0, 32'd50, 1'b1);
        check("t4.held_sum", act_sum[0], 64'd50);
        #2 rst = 1'b1;
        #1;
        check("t4.rst_valid", 64'(ov[0]), 64'd0);
        check("t4.rst_sum2", act_sum[0], 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        send(0, 32'd2, 1'b1);
        expect_result(0, "t4.after", 64'd2, 64'd1, 1'b0, 1'b0);

        // ACC_W=32: wrap sets overflow
        send(1, 32'hFFFF_FFFF, 1'b0);
        send(1, 32'd2, 1'b1);
        expect_result(1, "t5", 64'd1, 64'd2, 1'b1, 1'b0);

        // MAX_LEN=4: forced close, remainder continues
        for (int k = 1; k <= 6; k++) begin
            send(1, 32'd10, 1'b0);
            if (k == 4) expect_result(1, "t6.forced", 64'd40, 64'd4, 1'b0, 1'b1);
        end
        send(1, 32'd0, 1'b1);
        expect_result(1, "t6.rest", 64'd20, 64'd3, 1'b0, 1'b0);

        // MAX_LEN beat that also carries in_last is not forced
        for (int k = 1; k <= 4; k++) send(1, 32'd1, k == 4);
        expect_result(1, "t7", 64'd4, 64'd4, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream stage of the registered 16x16 unsigned multiplier. Consumes its 32-bit product stream, one product per accepted beat, and sums products into a wide accumulator until a beat tagged last (or MAX_LEN beats) closes the vector. It then presents the dot-product result, beat count and status flags on a valid/ready output port. It sits between the multiplier and the AXI/PS-facing result logic.

Parameters:
PROD_W, 32, width of incoming product (unsigned)
ACC_W, 48, accumulator/result width; must be >= PROD_W
MAX_LEN, 1024, maximum beats per vector; CNT_W = clog2(MAX_LEN+1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  product beat present; upstream aligns it with the multiplier's 1-cycle latency
in_product  in  PROD_W  unsigned product
in_last  in  1  beat is final element of vector
in_ready  out  1  stage can accept a beat this cycle
out_valid  out  1  result held
out_ready  in  1  downstream consumes result
out_sum  out  ACC_W  vector sum
out_count  out  CNT_W  beats in vector (1..MAX_LEN)
out_overflow  out  1  sum wrapped past 2^ACC_W at least once in vector
out_forced  out  1  vector closed by MAX_LEN, not by in_last

Behaviour:
- Reset (async assert, sync-safe deassert): state=ACCUM; acc=0; cnt=0; ovf=0; out_valid=0; out_sum=0; out_count=0; out_overflow=0; out_forced=0. Reset mid-vector discards the partial sum and any held result.
- States: ACCUM (collecting, no result held), DONE (result held, out_valid=1).
- in_ready = (state==ACCUM) | out_ready (combinational from out_ready). Beat accepted iff in_valid & in_ready. Non-accepted beats have no effect; in_last is ignored unless the beat is accepted.
- Arithmetic: sum_next = acc + zero_ext(in_product), modulo 2^ACC_W. The carry out of bit ACC_W-1 ORs into sticky ovf. No saturation.
- Accepted beat, not closing: acc<=sum_next; cnt<=cnt+1; ovf<=ovf|carry.
- Closing beat: in_last=1, or cnt+1==MAX_LEN.
  - out_sum<=sum_next; out_count<=cnt+1; out_overflow<=ovf|carry; out_forced<=~in_last.
  - acc<=0; cnt<=0; ovf<=0; state<=DONE.
- Latency: closing beat accepted at edge t -> out_valid=1 and outputs valid after edge t (first cycle t+1).
- DONE:
  - out_* stable while out_valid & ~out_ready.
  - out_ready=1 and no accepted beat: out_valid<=0; state<=ACCUM.
  - out_ready=1 with accepted non-closing beat: result retires; acc starts from 0 with that beat; state<=ACCUM.
  - out_ready=1 with accepted closing beat (e.g. 1-beat vector): new result loads, state stays DONE, out_valid stays 1. This gives back-to-back results at full throughput.
- Single-beat vector (in_last on first beat): out_count=1, out_sum=product.
- MAX_LEN beat that also has in_last=1: out_forced=0.
- Sustained rate: 1 beat/cycle with no bubbles while out_ready=1.

Decomposition:
- Shared package mult_stream_pkg:
  - PROD_W and ACC_W default constants.
  - acc_state_t enum {ACCUM, DONE}.
  - Function clog2 for CNT_W.
- No sub-module. The adder, counter and 2-state FSM stay inline; the block is one module.

Test Plan:
- Vector {3*4, 5*6, 7*8}=12,30,56, last on third, out_ready=1 -> out_sum=98, out_count=3, overflow=0, forced=0, out_valid one cycle after last beat.
- Hold out_ready=0 for 5 cycles after result -> in_ready=0; in_valid beats presented are not consumed; out_* stable; release out_ready -> result retires, next vector sums from 0.
- Continuous 1-beat vectors (in_last=1 every cycle, products 1,2,3,4), out_ready=1 -> out_valid held high, out_sum 1,2,3,4 on consecutive cycles, in_ready=1 throughout.
- ACC_W=32 build: products 0xFFFF_FFFF then 0x2, last -> out_sum=0x1, out_overflow=1.
- MAX_LEN=4, six beats of 10 with no in_last -> first result sum=40, count=4, forced=1; second vector open with acc=20, cnt=2.
- Assert rst mid-vector after 2 beats and again while DONE -> all outputs 0 immediately; next vector {2} with last -> out_sum=2, count=1.
